// File: rtl/dmem_bus_arbiter_if.sv
// Port bundle for dmem_bus_arbiter: core and debug request channels plus the shared Wishbone master side.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface dmem_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_op;
    logic [DW-1:0] core_rdata;
    logic          core_ack;
    logic          core_stall;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [2:0]    dbg_op;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_ack;
    logic          dbg_err;

    logic          bus_cyc;
    logic          bus_stb;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [2:0]    bus_op;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_op,
        output core_rdata, core_ack, core_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_op,
        output dbg_rdata, dbg_ack, dbg_err,
        output bus_cyc, bus_stb, bus_we, bus_addr, bus_wdata, bus_op,
        input  bus_rdata, bus_ack
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_op,
        input  core_rdata, core_ack, core_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_op,
        input  dbg_rdata, dbg_ack, dbg_err,
        input  bus_cyc, bus_stb, bus_we, bus_addr, bus_wdata, bus_op,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Round-robin arbiter sharing the data-memory Wishbone port between the core MEM stage and debug SBA.
// Optional ack timeout is compiled in with `define ARB_TIMEOUT_EN.
module dmem_bus_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic               clk,
    input logic               reset_n,
    dmem_bus_arbiter_if.slave arb
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CORE = 2'd1,
        S_DBG  = 2'd2
    } state_t;

    state_t state;
    logic   last_dbg;
    logic   timeout;
    logic   done;
    logic   core_pick;
    logic   core_ack_int;

    // Core wins when it is alone or when debug had the previous grant.
    assign core_pick = arb.core_req & (~arb.dbg_req | last_dbg);
    assign done      = (state != S_IDLE) & (arb.bus_ack | timeout);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CW-1:0] LAST_WAIT  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEADBEEF);

    logic [CW-1:0] wait_cnt;

    // A bus_ack on the last allowed cycle completes normally instead of aborting.
    assign timeout = (state != S_IDLE) & ~arb.bus_ack & (wait_cnt == LAST_WAIT);
`else
    // Without the timeout the arbiter waits for bus_ack forever.
    assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            last_dbg <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            // NOTE: non-blocking here so every register sees pre-edge values of the others.
            case (state)
                S_IDLE: begin
                    if (core_pick) begin
                        state <= S_CORE;
                    end else if (arb.dbg_req) begin
                        state <= S_DBG;
                    end
                end
                S_CORE, S_DBG: begin
                    if (done) begin
                        state    <= S_IDLE;
                        last_dbg <= (state == S_DBG);
                    end
                end
                default: state <= S_IDLE;
            endcase
`ifdef ARB_TIMEOUT_EN
            if (state == S_IDLE || done) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + CW'(1);
            end
`endif
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        arb.bus_cyc    = 1'b0;
        arb.bus_stb    = 1'b0;
        arb.bus_we     = 1'b0;
        arb.bus_addr   = {AW{1'b0}};
        arb.bus_wdata  = {DW{1'b0}};
        arb.bus_op     = 3'b000;
        core_ack_int   = 1'b0;
        arb.core_rdata = {DW{1'b0}};
        arb.dbg_ack    = 1'b0;
        arb.dbg_rdata  = {DW{1'b0}};
        case (state)
            S_CORE: begin
                arb.bus_cyc   = 1'b1;
                arb.bus_stb   = 1'b1;
                arb.bus_we    = arb.core_we;
                arb.bus_addr  = arb.core_addr;
                arb.bus_wdata = arb.core_wdata;
                arb.bus_op    = arb.core_op;
                core_ack_int  = arb.bus_ack | timeout;
                if (arb.bus_ack) begin
                    arb.core_rdata = arb.bus_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (timeout) begin
                    arb.core_rdata = ABORT_DATA;
                end
`endif
            end
            S_DBG: begin
                arb.bus_cyc   = 1'b1;
                arb.bus_stb   = 1'b1;
                arb.bus_we    = arb.dbg_we;
                arb.bus_addr  = arb.dbg_addr;
                arb.bus_wdata = arb.dbg_wdata;
                arb.bus_op    = arb.dbg_op;
                arb.dbg_ack   = arb.bus_ack;
                if (arb.bus_ack) begin
                    arb.dbg_rdata = arb.bus_rdata;
                end
            end
            default: ;
        endcase
    end

    assign arb.core_ack   = core_ack_int;
    assign arb.core_stall = arb.core_req & ~core_ack_int;
    assign arb.dbg_err    = (state == S_DBG) & timeout;
endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of the round-robin rules (timeout scenarios when ARB_TIMEOUT_EN is defined).
module tb_dmem_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO        = 8;
    localparam int MAX_DELAY = 10;
`else
    localparam int TO        = 255;
    localparam int MAX_DELAY = 3;
`endif

    typedef enum {NONE, CORE, DBG} who_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    dmem_bus_arbiter_if #(.AW(AW), .DW(DW)) arb ();

    dmem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .arb    (arb)
    );

    int   checks    = 0;
    int   failures  = 0;
    who_t m_owner   = NONE;
    who_t m_last    = DBG;
    int   m_wait    = 0;
    bit   core_done = 1'b0;
    bit   dbg_done  = 1'b0;

    int          s_cnt       = 0;
    int          s_delay     = 0;
    int          fixed_delay = -1;
    bit          spur_en     = 1'b0;
    bit          ack_fixed   = 1'b0;
    logic [31:0] ack_data    = 32'h0;
    bit          drain       = 1'b0;

    task automatic check(input string tag, input logic [31:0] seen, input logic [31:0] want);
        checks++;
        if (seen !== want) begin
            failures++;
            $display("FAIL %s seen=%08h want=%08h", tag, seen, want);
        end
    endtask

    // Who owns the bus next, given who is asking and who was served last.
    function automatic who_t pick(input bit c, input bit d, input who_t last);
        if (c && d) return (last == CORE) ? DBG : CORE;
        if (c) return CORE;
        if (d) return DBG;
        return NONE;
    endfunction

    function automatic bit model_timeout();
`ifdef ARB_TIMEOUT_EN
        return (m_owner != NONE) && (arb.bus_ack !== 1'b1) && (m_wait == TO - 1);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_owner   = NONE;
        m_last    = DBG;
        m_wait    = 0;
        core_done = 1'b0;
        dbg_done  = 1'b0;
    endtask

    task automatic new_core();
        arb.core_req   = 1'b1;
        arb.core_we    = 1'($urandom_range(1));
        arb.core_addr  = $urandom;
        arb.core_wdata = $urandom;
        arb.core_op    = 3'($urandom_range(7));
    endtask

    task automatic new_dbg();
        arb.dbg_req   = 1'b1;
        arb.dbg_we    = 1'($urandom_range(1));
        arb.dbg_addr  = $urandom;
        arb.dbg_wdata = $urandom;
        arb.dbg_op    = 3'($urandom_range(7));
    endtask

    task automatic drive_random();
        if (core_done) begin
            core_done = 1'b0;
            if (!drain && $urandom_range(1) == 1) new_core();
            else arb.core_req = 1'b0;
        end else if (!arb.core_req && !drain && $urandom_range(3) == 0) begin
            new_core();
        end
        if (dbg_done) begin
            dbg_done = 1'b0;
            if (!drain && $urandom_range(1) == 1) new_dbg();
            else arb.dbg_req = 1'b0;
        end else if (!arb.dbg_req && !drain && $urandom_range(3) == 0) begin
            new_dbg();
        end
    endtask

    // Wishbone slave: acks after s_delay wait cycles, garbage on rdata otherwise.
    task automatic drive_slave();
        if (arb.bus_stb) begin
            if (s_cnt >= s_delay) begin
                arb.bus_ack   = 1'b1;
                arb.bus_rdata = ack_fixed ? ack_data : $urandom;
                s_cnt         = 0;
            end else begin
                arb.bus_ack   = 1'b0;
                arb.bus_rdata = $urandom;
                s_cnt++;
            end
        end else begin
            s_cnt         = 0;
            s_delay       = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(MAX_DELAY));
            arb.bus_ack   = spur_en && ($urandom_range(5) == 0);
            arb.bus_rdata = $urandom;
        end
    endtask

    task automatic check_outputs();
        logic        e_act, e_we, e_cack, e_dack, e_err;
        logic [31:0] e_addr, e_wdata, e_crd, e_drd;
        logic [2:0]  e_op;
        bit          to;
        to      = model_timeout();
        e_act   = 1'b0; e_we = 1'b0; e_cack = 1'b0; e_dack = 1'b0; e_err = 1'b0;
        e_addr  = '0;   e_wdata = '0; e_crd = '0;   e_drd = '0;   e_op = '0;
        if (m_owner == CORE) begin
            e_act = 1'b1; e_we = arb.core_we; e_addr = arb.core_addr;
            e_wdata = arb.core_wdata; e_op = arb.core_op;
            e_cack = arb.bus_ack || to;
            e_crd  = arb.bus_ack ? arb.bus_rdata : (to ? 32'hDEADBEEF : 32'h0);
        end else if (m_owner == DBG) begin
            e_act = 1'b1; e_we = arb.dbg_we; e_addr = arb.dbg_addr;
            e_wdata = arb.dbg_wdata; e_op = arb.dbg_op;
            e_dack = arb.bus_ack;
            e_drd  = arb.bus_ack ? arb.bus_rdata : 32'h0;
            e_err  = to;
        end
        check("bus_cyc",    32'(arb.bus_cyc),    32'(e_act));
        check("bus_stb",    32'(arb.bus_stb),    32'(e_act));
        check("bus_we",     32'(arb.bus_we),     32'(e_we));
        check("bus_addr",   arb.bus_addr,        e_addr);
        check("bus_wdata",  arb.bus_wdata,       e_wdata);
        check("bus_op",     32'(arb.bus_op),     32'(e_op));
        check("core_ack",   32'(arb.core_ack),   32'(e_cack));
        check("core_rdata", arb.core_rdata,      e_crd);
        check("core_stall", 32'(arb.core_stall), 32'(arb.core_req && !e_cack));
        check("dbg_ack",    32'(arb.dbg_ack),    32'(e_dack));
        check("dbg_rdata",  arb.dbg_rdata,       e_drd);
        check("dbg_err",    32'(arb.dbg_err),    32'(e_err));
    endtask

    task automatic update_model();
        bit to;
        to = model_timeout();
        if (m_owner == NONE) begin
            m_owner = pick(arb.core_req, arb.dbg_req, m_last);
            m_wait  = 0;
        end else if (arb.bus_ack === 1'b1 || to) begin
            if (m_owner == CORE) core_done = 1'b1;
            else                 dbg_done  = 1'b1;
            m_last  = m_owner;
            m_owner = NONE;
        end else begin
            m_wait++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic finish_cycle();
        drive_slave();
        @(negedge clk);
        check_outputs();
        update_model();
    endtask

    task automatic wait_grant(input string tag, input logic [31:0] want_addr, input int want_lat);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            finish_cycle();
            n++;
            if (arb.bus_stb) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            check({tag, "_addr"}, arb.bus_addr, want_addr);
            check({tag, "_lat"}, n, want_lat);
        end else begin
            check({tag, "_no_grant"}, 32'(got), 32'd1);
        end
    endtask

    task automatic run_until_done(input string tag, input bit for_core, output int n_stb,
                                  output int n_ack, output int n_err, output int at_end,
                                  output logic [31:0] data);
        bit fin;
        n_stb = 0; n_ack = 0; n_err = 0; at_end = 0; data = '0; fin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            finish_cycle();
            if (arb.bus_stb) n_stb++;
            if (for_core ? arb.core_ack : arb.dbg_ack) begin
                n_ack++;
                at_end = n_stb;
                data   = for_core ? arb.core_rdata : arb.dbg_rdata;
            end
            if (arb.dbg_err) begin
                n_err++;
                at_end = n_stb;
            end
            if (for_core ? core_done : dbg_done) begin
                fin = 1'b1;
                break;
            end
        end
        check({tag, "_finished"}, 32'(fin), 32'd1);
    endtask

    task automatic drop_all();
        tick();
        arb.core_req = 1'b0;
        arb.dbg_req  = 1'b0;
        core_done    = 1'b0;
        dbg_done     = 1'b0;
        finish_cycle();
    endtask

    initial begin
        int          n_stb, n_ack, n_err, at_end;
        logic [31:0] data;
        bit          drained;

        arb.core_req = 1'b0; arb.core_we = 1'b0; arb.core_addr = '0; arb.core_wdata = '0; arb.core_op = '0;
        arb.dbg_req  = 1'b0; arb.dbg_we  = 1'b0; arb.dbg_addr  = '0; arb.dbg_wdata  = '0; arb.dbg_op  = '0;
        arb.bus_rdata = '0;  arb.bus_ack = 1'b0;
        model_reset();

        // Outputs idle while reset is held.
        repeat (2) begin
            @(negedge clk);
            check("rst_bus_cyc",  32'(arb.bus_cyc),  32'd0);
            check("rst_bus_stb",  32'(arb.bus_stb),  32'd0);
            check("rst_core_ack", 32'(arb.core_ack), 32'd0);
            check("rst_dbg_err",  32'(arb.dbg_err),  32'd0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        finish_cycle();

        // Both requesters held after reset: core first, then strict alternation.
        tick();
        arb.core_we = 1'b0; arb.core_addr = 32'h1000_0000; arb.core_op = 3'b010;
        arb.dbg_we  = 1'b0; arb.dbg_addr  = 32'h3000_0000; arb.dbg_op  = 3'b010;
        arb.core_req = 1'b1; arb.dbg_req = 1'b1;
        fixed_delay = 0;
        finish_cycle();
        wait_grant("alt0_core", 32'h1000_0000, 1);
        wait_grant("alt1_dbg",  32'h3000_0000, 2);
        wait_grant("alt2_core", 32'h1000_0000, 2);
        wait_grant("alt3_dbg",  32'h3000_0000, 2);
        drop_all();

        // Core read alone, slave acks on the third strobe cycle.
        tick();
        arb.core_we = 1'b0; arb.core_addr = 32'h2000_0010; arb.core_op = 3'b010; arb.core_req = 1'b1;
        fixed_delay = 2; ack_fixed = 1'b1; ack_data = 32'h1234_5678;
        finish_cycle();
        run_until_done("core_rd", 1'b1, n_stb, n_ack, n_err, at_end, data);
        check("core_rd_stb_cycles", n_stb, 32'd3);
        check("core_rd_ack_count",  n_ack, 32'd1);
        check("core_rd_ack_cycle",  at_end, 32'd3);
        check("core_rd_data",       data, 32'h1234_5678);
        ack_fixed = 1'b0;
        drop_all();

        // Debug write in flight while core starts requesting.
        tick();
        arb.dbg_we = 1'b1; arb.dbg_addr = 32'h0000_0100; arb.dbg_wdata = 32'hCAFE_F00D;
        arb.dbg_op = 3'b010; arb.dbg_req = 1'b1;
        arb.core_we = 1'b0; arb.core_addr = 32'h2000_0020; arb.core_op = 3'b010;
        fixed_delay = 4;
        finish_cycle();
        tick();
        arb.core_req = 1'b1;
        finish_cycle();
        for (int i = 0; i < 20; i++) begin
            tick();
            finish_cycle();
            check("dbgwr_bus_addr",   arb.bus_addr,        32'h0000_0100);
            check("dbgwr_bus_wdata",  arb.bus_wdata,       32'hCAFE_F00D);
            check("dbgwr_core_stall", 32'(arb.core_stall), 32'd1);
            if (dbg_done) break;
        end
        check("dbgwr_finished", 32'(dbg_done), 32'd1);
        tick();
        arb.dbg_req = 1'b0;
        dbg_done    = 1'b0;
        finish_cycle();
        wait_grant("dbgwr_core_next", 32'h2000_0020, 1);
        fixed_delay = 1;
        run_until_done("dbgwr_core", 1'b1, n_stb, n_ack, n_err, at_end, data);
        drop_all();

        // Reset asserted mid-transaction with bus_ack high: nothing completes.
        tick();
        arb.core_we = 1'b1; arb.core_addr = 32'h2000_0030; arb.core_wdata = 32'h0BAD_F00D;
        arb.core_req = 1'b1;
        fixed_delay = 100;
        finish_cycle();
        wait_grant("rst_core_grant", 32'h2000_0030, 1);
        tick();
        arb.dbg_we = 1'b0; arb.dbg_addr = 32'h0000_0200; arb.dbg_op = 3'b010; arb.dbg_req = 1'b1;
        arb.bus_ack = 1'b1; arb.bus_rdata = 32'h5555_AAAA;
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_bus_cyc",  32'(arb.bus_cyc),  32'd0);
        check("rstmid_bus_stb",  32'(arb.bus_stb),  32'd0);
        check("rstmid_bus_we",   32'(arb.bus_we),   32'd0);
        check("rstmid_core_ack", 32'(arb.core_ack), 32'd0);
        check("rstmid_dbg_ack",  32'(arb.dbg_ack),  32'd0);
        model_reset();
        arb.core_req = 1'b0;
        arb.bus_ack  = 1'b0;
        fixed_delay  = 1;
        @(negedge clk);
        check("rstmid_hold_stb", 32'(arb.bus_stb), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        finish_cycle();
        wait_grant("rst_dbg_grant", 32'h0000_0200, 1);
        run_until_done("rst_dbg", 1'b0, n_stb, n_ack, n_err, at_end, data);
        drop_all();

`ifdef ARB_TIMEOUT_EN
        // Unmapped debug read: abort with dbg_err on the TO-th granted cycle.
        tick();
        arb.dbg_we = 1'b0; arb.dbg_addr = 32'hF000_0000; arb.dbg_req = 1'b1;
        fixed_delay = 1000;
        finish_cycle();
        run_until_done("to_dbg", 1'b0, n_stb, n_ack, n_err, at_end, data);
        check("to_dbg_err_count", n_err,  32'd1);
        check("to_dbg_err_cycle", at_end, TO);
        check("to_dbg_ack_count", n_ack,  32'd0);
        drop_all();
        check("to_dbg_stb_drop", 32'(arb.bus_stb), 32'd0);

        // Same for the core: it gets an ack with the poison word.
        tick();
        arb.core_we = 1'b0; arb.core_addr = 32'hF000_0004; arb.core_req = 1'b1;
        finish_cycle();
        run_until_done("to_core", 1'b1, n_stb, n_ack, n_err, at_end, data);
        check("to_core_ack_count", n_ack,  32'd1);
        check("to_core_ack_cycle", at_end, TO);
        check("to_core_data",      data,   32'hDEADBEEF);
        drop_all();

        // bus_ack exactly on the timeout cycle completes normally.
        tick();
        arb.dbg_we = 1'b0; arb.dbg_addr = 32'h0000_0300; arb.dbg_req = 1'b1;
        fixed_delay = TO - 1; ack_fixed = 1'b1; ack_data = 32'hA5A5_0001;
        finish_cycle();
        run_until_done("to_race", 1'b0, n_stb, n_ack, n_err, at_end, data);
        check("to_race_ack_count", n_ack,  32'd1);
        check("to_race_err_count", n_err,  32'd0);
        check("to_race_ack_cycle", at_end, TO);
        check("to_race_data",      data,   32'hA5A5_0001);
        ack_fixed = 1'b0;
        drop_all();
`endif

        // Randomized traffic, spurious acks while idle included.
        fixed_delay = -1;
        spur_en     = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            drive_random();
            finish_cycle();
        end
        drain   = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            drive_random();
            finish_cycle();
            if (!arb.core_req && !arb.dbg_req && m_owner == NONE) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain_idle", 32'(drained), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
